// File: rtl/register_access_arbiter.sv
// Round-robin arbiter sharing one register-bank port between N_REQ framed command sources.
// Each accepted frame becomes one bank write, one latency-timed read, or an error response.
module register_access_arbiter #(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int N_REQ       = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                                        clk,
  input  logic                                        i_reset,
  input  logic [N_REQ*(VALUE_WORDS+2)*WORD_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]                            i_req_valid,
  output logic [N_REQ-1:0]                            o_req_ready,
  output logic                                        o_w_en,
  output logic                                        o_r_en,
  output logic [WORD_WIDTH-1:0]                       o_addr,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0]           o_value,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0]           i_rd_data,
  output logic [N_REQ-1:0]                            o_rsp_valid,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0]           o_rsp_data,
  output logic                                        o_rsp_err,
  output logic                                        o_busy
);
  localparam int VW = VALUE_WORDS * WORD_WIDTH;
  localparam int FW = VW + 2 * WORD_WIDTH;
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [WORD_WIDTH-1:0] CMD_WRITE = WORD_WIDTH'('hAA);
  localparam logic [WORD_WIDTH-1:0] CMD_READ  = '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [CW-1:0]   rd_cnt;
  logic            cmd_rd;
  logic            cmd_err;

  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic            any_valid;
  logic [FW-1:0]   sel_frame;
  logic [WORD_WIDTH-1:0] sel_cmd;
  logic            sel_is_wr;
  logic            sel_is_rd;

  // Search starts one past the previous winner, so continuous requesters take turns.
  always_comb begin
    win       = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % N_REQ);
      if (!any_valid && i_req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  assign sel_frame = i_req_data[int'(win)*FW +: FW];
  assign sel_cmd   = sel_frame[FW-1 -: WORD_WIDTH];
  assign sel_is_wr = (sel_cmd == CMD_WRITE);
  assign sel_is_rd = (sel_cmd == CMD_READ);

  // Handshake: a frame transfers in the IDLE cycle where i_req_valid[k] and o_req_ready[k]
  // are both high; requests arriving while busy are not stored and must be held or re-presented.
  assign o_req_ready = (state == IDLE && any_valid && !i_reset) ? (N_REQ'(1) << win) : '0;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      last_grant  <= GW'(N_REQ - 1);
      rd_cnt      <= '0;
      cmd_rd      <= 1'b0;
      cmd_err     <= 1'b0;
      o_w_en      <= 1'b0;
      o_r_en      <= 1'b0;
      o_addr      <= '0;
      o_value     <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            last_grant <= win;
            o_addr     <= sel_frame[FW-WORD_WIDTH-1 -: WORD_WIDTH];
            o_value    <= sel_frame[VW-1:0];
            o_w_en     <= sel_is_wr;
            o_r_en     <= sel_is_rd;
            cmd_rd     <= sel_is_rd;
            cmd_err    <= !(sel_is_wr || sel_is_rd);
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          o_w_en <= 1'b0;
          o_r_en <= 1'b0;
          if (cmd_rd) begin
            rd_cnt <= CW'(RD_LATENCY);
            state  <= WAIT_RD;
          end else begin
            o_rsp_valid <= N_REQ'(1) << last_grant;
            o_rsp_err   <= cmd_err;
            o_rsp_data  <= '0;
            state       <= RESP;
          end
        end
        WAIT_RD: begin
          if (rd_cnt == CW'(1)) begin
            o_rsp_valid <= N_REQ'(1) << last_grant;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= i_rd_data;
            state       <= RESP;
          end else begin
            rd_cnt <= rd_cnt - CW'(1);
          end
        end
        RESP: begin
          o_rsp_valid <= '0;
          o_rsp_err   <= 1'b0;
          o_rsp_data  <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge clk) disable iff (i_reset) !(o_w_en && o_r_en));
  a_ready_oh:    assert property (@(posedge clk) disable iff (i_reset) $onehot0(o_req_ready));
  a_rsp_oh:      assert property (@(posedge clk) disable iff (i_reset) $onehot0(o_rsp_valid));

endmodule

// File: tb/tb_register_access_arbiter.sv
// Bench for register_access_arbiter with three requesters and a two-cycle read latency.
// Covers directed single transactions, fairness, reset corners, wrap and a randomized run.
module tb_register_access_arbiter;
  localparam int W  = 8;
  localparam int VWORDS = 4;
  localparam int N  = 3;
  localparam int L  = 2;
  localparam int VW = VWORDS * W;
  localparam int FW = VW + 2 * W;
  localparam int EW = N + 1 + VW;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N*FW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic            w_en, r_en;
  logic [W-1:0]    addr;
  logic [VW-1:0]   value;
  logic [VW-1:0]   rd_data;
  logic [N-1:0]    rsp_valid;
  logic [VW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  register_access_arbiter #(
    .WORD_WIDTH(W), .VALUE_WORDS(VWORDS), .N_REQ(N), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_req_data(req_data), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .o_w_en(w_en), .o_r_en(r_en), .o_addr(addr), .o_value(value),
    .i_rd_data(rd_data), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err), .o_busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset   = 1'b1;
    req_valid = '0;
    next();
    next();
    i_reset = 1'b0;
  endtask

  // checking helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  // driver tasks
  task automatic set_frame(input int k, input logic [W-1:0] c, input logic [W-1:0] a,
                           input logic [VW-1:0] v);
    req_data[k*FW +: FW] = {c, a, v};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_wen"}, w_en, 0);
    check({tag, "_ren"}, r_en, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_value"}, value, 0);
    check({tag, "_rspv"}, rsp_valid, 0);
    check({tag, "_rspd"}, rsp_data, 0);
    check({tag, "_rspe"}, rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    int            req;
    logic [W-1:0]  cmd;
    logic [W-1:0]  a;
    logic [VW-1:0] v;
    logic [VW-1:0] rd;
    logic [N-1:0]  exp_ready;
    logic          exp_w;
    logic          exp_r;
    int            exp_lat;
    logic [VW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t t);
    req_valid = '0;
    req_valid[t.req] = 1'b1;
    set_frame(t.req, t.cmd, t.a, t.v);
    @(negedge clk);
    check("vec_ready", req_ready, t.exp_ready);
    check("vec_idle", busy, 0);
    next();
    req_valid = '0;
    @(negedge clk);
    check("vec_wen", w_en, t.exp_w);
    check("vec_ren", r_en, t.exp_r);
    check("vec_addr", addr, t.a);
    check("vec_value", value, t.v);
    check("vec_busy", busy, 1);
    for (int c = 2; c <= t.exp_lat; c++) begin
      next();
      rd_data = (c == 1 + L) ? t.rd : VW'($urandom());
      @(negedge clk);
      check("vec_strobe_off", {w_en, r_en}, 0);
      if (c == t.exp_lat) begin
        check("vec_rspv", rsp_valid, t.exp_ready);
        check("vec_rspd", rsp_data, t.exp_data);
        check("vec_rspe", rsp_err, t.exp_err);
      end else begin
        check("vec_rspv_early", rsp_valid, 0);
      end
    end
    next();
    @(negedge clk);
    check("vec_rsp_done", rsp_valid, 0);
    check("vec_busy_done", busy, 0);
    next();
  endtask

  // randomized run against a transaction-level model
  task automatic random_run(input int cycles);
    int m_ptr, m_acc, m_resp, m_free, m_kind, g;
    logic [W-1:0] m_addr, f_cmd;
    logic [VW-1:0] m_value;
    logic [FW-1:0] f;
    logic [N-1:0] drop, exp_ready;
    logic [EW-1:0] e;
    int sel;
    bit found;
    m_ptr = N - 1; m_acc = -1; m_resp = -1; m_free = 0; m_kind = 0;
    m_addr = '0; m_value = '0; drop = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (drop[k]) req_valid[k] = 1'b0;
        else if (req_valid[k] && $urandom_range(0, 9) == 0) req_valid[k] = 1'b0;
        else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          sel = $urandom_range(0, 3);
          f_cmd = (sel < 2) ? 8'hAA : (sel == 2) ? 8'h00 : W'($urandom());
          req_valid[k] = 1'b1;
          set_frame(k, f_cmd, W'($urandom()), VW'($urandom()));
        end
      end
      drop = '0;
      rd_data = VW'($urandom());
      @(negedge clk);
      check("rnd_wen", w_en, (m_acc >= 0 && cyc == m_acc + 1 && m_kind == 0));
      check("rnd_ren", r_en, (m_acc >= 0 && cyc == m_acc + 1 && m_kind == 1));
      check("rnd_addr", addr, m_addr);
      check("rnd_value", value, m_value);
      check("rnd_busy", busy, (m_acc >= 0 && cyc > m_acc && cyc <= m_resp));
      if (m_acc >= 0 && m_kind == 1 && cyc == m_acc + 1 + L)
        exp_q.push_back({oh(g), 1'b0, rd_data});
      if (cyc == m_resp) begin
        if (exp_q.size() == 0) begin
          check("rnd_q_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_rsp", {rsp_valid, rsp_err, rsp_data}, e);
        end
      end else begin
        check("rnd_rspv_idle", rsp_valid, 0);
      end
      exp_ready = '0;
      found = 1'b0;
      if (cyc >= m_free) begin
        for (int s = 1; s <= N; s++) begin
          if (!found && req_valid[(m_ptr + s) % N]) begin
            found = 1'b1;
            g = (m_ptr + s) % N;
          end
        end
      end
      if (found) begin
        exp_ready = oh(g);
        f = req_data[g*FW +: FW];
        m_ptr = g;
        m_acc = cyc;
        m_addr = f[FW-W-1 -: W];
        m_value = f[VW-1:0];
        m_kind = (f[FW-1 -: W] == 8'hAA) ? 0 : (f[FW-1 -: W] == 8'h00) ? 1 : 2;
        m_resp = cyc + 2 + ((m_kind == 1) ? L : 0);
        m_free = m_resp + 1;
        if (m_kind != 1) exp_q.push_back({oh(g), (m_kind == 2), {VW{1'b0}}});
        drop[g] = 1'b1;
      end
      check("rnd_ready", req_ready, exp_ready);
      next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    vecs[0] = '{0, 8'hAA, 8'h05, 32'hDEADBEEF, 32'h0,        3'b001, 1, 0, 2, 32'h0,        0};
    vecs[1] = '{1, 8'h00, 8'h3C, 32'h0,        32'h12345678, 3'b010, 0, 1, 4, 32'h12345678, 0};
    vecs[2] = '{0, 8'h55, 8'h10, 32'h01020304, 32'h0,        3'b001, 0, 0, 2, 32'h0,        1};
    vecs[3] = '{2, 8'h00, 8'h7F, 32'hAAAAAAAA, 32'hCAFEF00D, 3'b100, 0, 1, 4, 32'hCAFEF00D, 0};
    vecs[4] = '{1, 8'hAB, 8'h22, 32'h55555555, 32'h0,        3'b010, 0, 0, 2, 32'h0,        1};
    vecs[5] = '{2, 8'hAA, 8'hFF, 32'hFFFFFFFF, 32'h0,        3'b100, 1, 0, 2, 32'h0,        0};
    vecs[6] = '{0, 8'h01, 8'h80, 32'h80000001, 32'h0,        3'b001, 0, 0, 2, 32'h0,        1};

    i_reset = 1'b1;
    req_data = '0;
    req_valid = 3'b011;
    rd_data = '0;
    next();
    next();
    check_all_zero("rst");
    req_valid = '0;
    i_reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // fairness: req0 and req1 write continuously
    do_reset();
    set_frame(0, 8'hAA, 8'h01, 32'h11111111);
    set_frame(1, 8'hAA, 8'h02, 32'h22222222);
    req_valid = 3'b011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("fair_ready", req_ready, (c % 3 == 0) ? oh((c / 3) % 2) : 3'b000);
      check("fair_rsp", rsp_valid, (c % 3 == 2) ? oh((c / 3) % 2) : 3'b000);
      next();
    end
    req_valid = '0;
    next(); next(); next();

    // reset while a read from req0 waits for bank data
    set_frame(0, 8'h00, 8'h44, 32'h0);
    req_valid = 3'b001;
    @(negedge clk);
    check("rr_accept", req_ready, 3'b001);
    next();
    req_valid = '0;
    next();
    @(negedge clk);
    check("rr_in_wait", busy, 1);
    #1;
    i_reset = 1'b1;
    set_frame(0, 8'hAA, 8'h0A, 32'hA0A0A0A0);
    set_frame(1, 8'hAA, 8'h0B, 32'hB0B0B0B0);
    req_valid = 3'b011;
    #1;
    check_all_zero("rr_async");
    for (int c = 0; c < 3; c++) begin
      next();
      check("rr_no_rsp", rsp_valid, 0);
    end
    i_reset = 1'b0;
    @(negedge clk);
    check("rr_restart_req0", req_ready, 3'b001);
    next();
    req_valid = 3'b010;
    next(); next();
    @(negedge clk);
    check("rr_req1_accept", req_ready, 3'b010);
    next();
    req_valid = '0;
    next(); next(); next();

    // reset while a write strobe is high
    set_frame(2, 8'hAA, 8'h33, 32'h33333333);
    req_valid = 3'b100;
    next();
    req_valid = '0;
    check("rw_strobe", w_en, 1);
    i_reset = 1'b1;
    #1;
    check("rw_strobe_drop", w_en, 0);
    check("rw_addr_clr", addr, 0);
    next();
    i_reset = 1'b0;

    // wrap: req2 alone, then req0 and req2 together
    set_frame(2, 8'hAA, 8'h20, 32'h20202020);
    req_valid = 3'b100;
    @(negedge clk);
    check("wrap_req2", req_ready, 3'b100);
    next();
    req_valid = '0;
    next(); next();
    set_frame(0, 8'hAA, 8'h00, 32'h00000000);
    req_valid = 3'b101;
    @(negedge clk);
    check("wrap_req0", req_ready, 3'b001);
    next();
    req_valid = 3'b100;
    next(); next();
    @(negedge clk);
    check("wrap_req2_next", req_ready, 3'b100);
    next();
    req_valid = '0;
    next(); next(); next();

    do_reset();
    random_run(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
